// File: rtl/noc_switch_allocator_if.sv
// Handshake bundle between input FIFOs, crossbar and the switch allocator.
// The upstream/downstream side is the master; the allocator is the slave.
interface noc_switch_allocator_if #(
    parameter int NPORTS = 5
);
    logic [NPORTS-1:0]        req_valid;
    logic [NPORTS*NPORTS-1:0] req_dest;
    logic [NPORTS-1:0]        req_tail;
    logic [NPORTS-1:0]        credit_in;
    logic [NPORTS-1:0]        grant;
    logic [NPORTS-1:0]        out_valid;
    logic [NPORTS*NPORTS-1:0] xbar_sel;
    logic                     err;

    modport master (
        output req_valid,
        output req_dest,
        output req_tail,
        output credit_in,
        input  grant,
        input  out_valid,
        input  xbar_sel,
        input  err
    );

    modport slave (
        input  req_valid,
        input  req_dest,
        input  req_tail,
        input  credit_in,
        output grant,
        output out_valid,
        output xbar_sel,
        output err
    );
endinterface

// File: rtl/noc_switch_allocator.sv
// Wormhole switch allocator: one round-robin IDLE/BUSY FSM per output,
// credit-gated flit transfer, registered crossbar select.
module noc_switch_allocator #(
    parameter int NPORTS  = 5,
    parameter int CREDITS = 4
) (
    input logic                   clk,
    input logic                   rst,
    noc_switch_allocator_if.slave sw
);
    localparam int CW = $clog2(CREDITS + 1);
    localparam int IW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NPORTS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e            state_q   [NPORTS];
    state_e            state_d   [NPORTS];
    logic [IW-1:0]     owner_q   [NPORTS];
    logic [IW-1:0]     owner_d   [NPORTS];
    logic [IW-1:0]     rr_last_q [NPORTS];
    logic [IW-1:0]     rr_last_d [NPORTS];
    logic [CW-1:0]     credit_q  [NPORTS];
    logic [CW-1:0]     credit_d  [NPORTS];
    logic [NPORTS-1:0] xbar_q    [NPORTS];
    logic [NPORTS-1:0] xbar_d    [NPORTS];
    logic              err_q;
    logic              err_d;

    logic [NPORTS-1:0] dest [NPORTS];
    logic [NPORTS-1:0] cand [NPORTS];
    logic [IW:0]       pick [NPORTS];
    logic [NPORTS-1:0] req_ok;
    logic [NPORTS-1:0] bad_req;
    logic [NPORTS-1:0] owned;
    logic [NPORTS-1:0] send;
    logic [NPORTS-1:0] grant_c;
    logic [NPORTS*NPORTS-1:0] xbar_flat;

    // Returns {found, index}: first set bit of cand after last, wrapping.
    function automatic logic [IW:0] rr_pick(
        input logic [NPORTS-1:0] c,
        input logic [IW-1:0]     last
    );
        logic [IW:0] r;
        int          idx;
        r = '0;
        for (int k = NPORTS; k >= 1; k--) begin
            idx = (int'(last) + k) % NPORTS;
            if (c[IW'(idx)]) begin
                r = {1'b1, IW'(idx)};
            end
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            dest[i]    = sw.req_dest[i*NPORTS +: NPORTS];
            req_ok[i]  = sw.req_valid[i] & $onehot(dest[i]);
            bad_req[i] = sw.req_valid[i] & ~$onehot(dest[i]);
        end
    end

    always_comb begin
        owned = '0;
        for (int o = 0; o < NPORTS; o++) begin
            if (state_q[o] == BUSY) begin
                owned[owner_q[o]] = 1'b1;
            end
        end
    end

    always_comb begin
        for (int o = 0; o < NPORTS; o++) begin
            for (int i = 0; i < NPORTS; i++) begin
                cand[o][i] = req_ok[i] & dest[i][o] & ~owned[i];
            end
            pick[o] = rr_pick(cand[o], rr_last_q[o]);
        end
    end

    // A flit moves only from a locked owner with a free downstream slot.
    always_comb begin
        send = '0;
        for (int o = 0; o < NPORTS; o++) begin
            send[o] = ~rst
                    & (state_q[o] == BUSY)
                    & sw.req_valid[owner_q[o]]
                    & (credit_q[o] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < NPORTS; o++) begin
                state_q[o]   <= IDLE;
                owner_q[o]   <= '0;
                rr_last_q[o] <= LAST_IDX;
                credit_q[o]  <= CRED_MAX;
                xbar_q[o]    <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int o = 0; o < NPORTS; o++) begin
                state_q[o]   <= state_d[o];
                owner_q[o]   <= owner_d[o];
                rr_last_q[o] <= rr_last_d[o];
                credit_q[o]  <= credit_d[o];
                xbar_q[o]    <= xbar_d[o];
            end
            err_q <= err_d;
        end
    end

    always_comb begin
        err_d = err_q | (|bad_req);
        for (int o = 0; o < NPORTS; o++) begin
            state_d[o]   = state_q[o];
            owner_d[o]   = owner_q[o];
            rr_last_d[o] = rr_last_q[o];
            credit_d[o]  = credit_q[o];
            xbar_d[o]    = xbar_q[o];

            unique case (state_q[o])
                IDLE: begin
                    if (pick[o][IW]) begin
                        state_d[o] = BUSY;
                        owner_d[o] = pick[o][IW-1:0];
                        xbar_d[o]  = NPORTS'(1) << pick[o][IW-1:0];
                    end
                end
                BUSY: begin
                    if (send[o] && sw.req_tail[owner_q[o]]) begin
                        state_d[o]   = IDLE;
                        rr_last_d[o] = owner_q[o];
                        xbar_d[o]    = '0;
                    end
                end
            endcase

            // Simultaneous send and credit return cancel out.
            unique case ({send[o], sw.credit_in[o]})
                2'b10: credit_d[o] = credit_q[o] - CW'(1);
                2'b01: begin
                    if (credit_q[o] == CRED_MAX) begin
                        err_d = 1'b1;
                    end else begin
                        credit_d[o] = credit_q[o] + CW'(1);
                    end
                end
                default: credit_d[o] = credit_q[o];
            endcase
        end
    end

    always_comb begin
        grant_c = '0;
        for (int o = 0; o < NPORTS; o++) begin
            if (send[o]) begin
                grant_c[owner_q[o]] = 1'b1;
            end
        end
    end

    always_comb begin
        xbar_flat = '0;
        for (int o = 0; o < NPORTS; o++) begin
            xbar_flat[o*NPORTS +: NPORTS] = xbar_q[o];
        end
    end

    assign sw.grant     = grant_c;
    assign sw.out_valid = send;
    assign sw.xbar_sel  = xbar_flat;
    assign sw.err       = err_q;
endmodule

// File: tb/tb_noc_switch_allocator.sv
// Random and directed stimulus for noc_switch_allocator, checked
// against a packet-level reference model of the allocator.
module tb_noc_switch_allocator;
    localparam int NP = 5;
    localparam int CR = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    noc_switch_allocator_if #(.NPORTS(NP)) sw();

    noc_switch_allocator #(
        .NPORTS (NP),
        .CREDITS(CR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw (sw.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference: owner is -1 when an output is free.
    int own  [NP];
    int rrl  [NP];
    int cred [NP];
    bit merr;
    logic [NP-1:0] exp_grant;
    logic [NP-1:0] exp_ov;

    int rem [NP];
    int dst [NP];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [NP-1:0] dslice(input int i);
        return sw.req_dest[i*NP +: NP];
    endfunction

    function automatic bit vreq(input int i);
        return sw.req_valid[i] && ($countones(dslice(i)) == 1);
    endfunction

    function automatic logic [NP*NP-1:0] exp_xbar();
        logic [NP*NP-1:0] x;
        x = '0;
        for (int o = 0; o < NP; o++) begin
            if (own[o] >= 0) x[o*NP + own[o]] = 1'b1;
        end
        return x;
    endfunction

    task automatic reset_model();
        for (int o = 0; o < NP; o++) begin
            own[o]  = -1;
            rrl[o]  = NP - 1;
            cred[o] = CR;
        end
        merr = 1'b0;
    endtask

    task automatic clear_in();
        sw.req_valid = '0;
        sw.req_dest  = '0;
        sw.req_tail  = '0;
        sw.credit_in = '0;
    endtask

    // Compare one cycle, advance the model, then step past the edge.
    task automatic tick();
        bit   snd  [NP];
        int   nown [NP];
        int   i;
        bit   busy_in;
        logic [NP-1:0] d;
        #1;
        exp_grant = '0;
        exp_ov    = '0;
        for (int o = 0; o < NP; o++) begin
            snd[o] = !rst && own[o] >= 0 && sw.req_valid[own[o]]
                     && cred[o] > 0;
            if (snd[o]) begin
                exp_grant[own[o]] = 1'b1;
                exp_ov[o]         = 1'b1;
            end
        end
        check("grant", sw.grant, exp_grant);
        check("out_valid", sw.out_valid, exp_ov);
        check("xbar_sel", sw.xbar_sel, exp_xbar());
        check("err", sw.err, merr);
        if (rst) begin
            reset_model();
        end else begin
            for (int k = 0; k < NP; k++) begin
                if (sw.req_valid[k] && $countones(dslice(k)) != 1)
                    merr = 1'b1;
            end
            nown = own;
            for (int o = 0; o < NP; o++) begin
                if (own[o] < 0) begin
                    for (int s = 1; s <= NP; s++) begin
                        i = (rrl[o] + s) % NP;
                        busy_in = 1'b0;
                        for (int p = 0; p < NP; p++)
                            if (own[p] == i) busy_in = 1'b1;
                        d = dslice(i);
                        if (nown[o] < 0 && vreq(i) && d[o] && !busy_in)
                            nown[o] = i;
                    end
                end else if (snd[o] && sw.req_tail[own[o]]) begin
                    nown[o] = -1;
                    rrl[o]  = own[o];
                end
                if (snd[o] && !sw.credit_in[o]) begin
                    cred[o]--;
                end else if (!snd[o] && sw.credit_in[o]) begin
                    if (cred[o] == CR) merr = 1'b1;
                    else cred[o]++;
                end
            end
            own = nown;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand();
        logic [NP-1:0]    v, t, c;
        logic [NP*NP-1:0] d;
        v = '0; t = '0; c = '0; d = '0;
        for (int i = 0; i < NP; i++) begin
            if (rem[i] == 0 && $urandom_range(0, 3) == 0) begin
                rem[i] = $urandom_range(1, 6);
                dst[i] = $urandom_range(0, NP - 1);
            end
            if (rem[i] > 0) begin
                v[i] = ($urandom_range(0, 7) != 0);
                d[i*NP + dst[i]] = 1'b1;
                t[i] = (rem[i] == 1);
            end
        end
        for (int o = 0; o < NP; o++)
            c[o] = cred[o] < CR && $urandom_range(0, 3) == 0;
        sw.req_valid = v;
        sw.req_dest  = d;
        sw.req_tail  = t;
        sw.credit_in = c;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_in();
        tick();
        rst = 1'b0;
    endtask

    int sent;
    int ng;

    initial begin
        rst = 1'b1;
        clear_in();
        for (int i = 0; i < NP; i++) rem[i] = 0;
        @(posedge clk);
        #1;
        reset_model();
        tick();
        rst = 1'b0;
        #1;
        check("rst_xbar", sw.xbar_sel, 0);
        check("rst_err", sw.err, 0);
        check("rst_grant", sw.grant, 0);
        tick();

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) begin
                rst = 1'b1;
                drive_rand();
                tick();
                rst = 1'b0;
                for (int i = 0; i < NP; i++) rem[i] = 0;
            end else begin
                drive_rand();
                tick();
                for (int i = 0; i < NP; i++)
                    if (exp_grant[i]) rem[i]--;
            end
        end

        // Single flit from input 2 to output 1.
        do_reset();
        sw.req_valid = 5'b00100;
        sw.req_dest[14:10] = 5'b00010;
        sw.req_tail  = 5'b00100;
        tick();
        check("t1_sel", sw.xbar_sel[9:5], 5'b00100);
        check("t1_grant", sw.grant, 5'b00100);
        check("t1_ov", sw.out_valid, 5'b00010);
        tick();
        clear_in();
        check("t1_free", sw.xbar_sel[9:5], 0);
        tick();

        // Non-one-hot destination, then credit overflow.
        do_reset();
        sw.req_valid = 5'b00001;
        sw.req_dest[4:0] = 5'b00110;
        #1;
        check("t6_nogrant", sw.grant, 0);
        tick();
        check("t6_err", sw.err, 1);
        clear_in();
        sw.credit_in = 5'b01000;
        tick();
        clear_in();
        check("t6_sticky", sw.err, 1);
        tick();
        do_reset();
        sw.credit_in = 5'b01000;
        tick();
        clear_in();
        check("sat_err", sw.err, 1);

        // 7-flit packet from input 4 to output 3, starting at full credit.
        sent = 0;
        ng   = 0;
        for (int c = 0; c < 8; c++) begin
            sw.req_valid = 5'b10000;
            sw.req_dest[24:20] = 5'b01000;
            sw.req_tail = (sent == 6) ? 5'b10000 : 5'b00000;
            #1;
            ng += int'(sw.grant[4]);
            tick();
            if (exp_grant[4]) sent++;
        end
        check("t4_grants", ng, 4);
        check("t4_stall_ov", sw.out_valid, 0);
        sw.credit_in = 5'b01000;
        tick();
        sw.credit_in = 5'b00000;
        #1;
        check("t4_resume", sw.grant, 5'b10000);
        tick();
        #1;
        check("t4_stall", sw.grant, 0);
        sw.credit_in = 5'b01000;
        tick();
        sw.req_tail = 5'b00000;
        #1;
        check("t4_cisend", sw.grant, 5'b10000);
        tick();
        sw.credit_in = 5'b00000;
        sw.req_tail  = 5'b10000;
        #1;
        check("t4_kept", sw.grant, 5'b10000);
        tick();
        clear_in();
        check("t4_done", sw.xbar_sel[19:15], 0);
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
